// File: rtl/cgra_cmem_loader.sv
// Copies a kernel image from system memory into CGRA context memory via an OBI-style read master and a FIFO.
// Latency: first cm_req_o appears 1 (start) + 1 (mem req) + memory read latency cycles after start_i.
// Backpressure: reads are credit-limited to FIFO_DEPTH words in flight or buffered; cm_gnt_i stalls the FIFO head.

module cgra_cmem_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wptr] <= push_dat_i;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (pop_i) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign head_dat_o = r_mem[r_rptr];
    assign count_o    = r_count;
    assign empty_o    = (r_count == '0);
endmodule

module cgra_cmem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  cm_req_o,
    output logic [ADDR_WIDTH-1:0] cm_add_o,
    output logic                  cm_we_o,
    output logic [3:0]            cm_be_o,
    output logic [DATA_WIDTH-1:0] cm_wdata_o,
    input  logic                  cm_gnt_i,
    input  logic                  cm_rvalid_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_rd_issued;
    logic [LEN_WIDTH-1:0]  r_wr_issued;
    logic [CW-1:0]         r_rd_out;
    logic [LEN_WIDTH-1:0]  r_cm_out;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_mem_req;
    logic                  w_rd_hs;
    logic                  w_push;
    logic                  w_cm_req;
    logic                  w_wr_hs;
    logic                  w_cm_ack;
    logic [LEN_WIDTH-1:0]  w_cm_out_nxt;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_empty;

    // Credit rule: buffered plus in-flight reads never exceed the FIFO, so a push can never overflow.
    assign w_mem_req = (r_state == S_RUN) && (r_rd_issued < r_len) &&
                       (({1'b0, w_fifo_count} + {1'b0, r_rd_out}) < (CW+1)'(FIFO_DEPTH));
    assign w_rd_hs   = w_mem_req && mem_gnt_i;
    assign w_push    = mem_rvalid_i && (r_rd_out != '0);
    assign w_cm_req  = (r_state == S_RUN) && !w_fifo_empty;
    assign w_wr_hs   = w_cm_req && cm_gnt_i;
    assign w_cm_ack  = cm_rvalid_i && (r_cm_out != '0);
    assign w_cm_out_nxt = r_cm_out + LEN_WIDTH'(w_wr_hs) - LEN_WIDTH'(w_cm_ack);

    cgra_cmem_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (w_push),
        .push_dat_i (mem_rdata_i),
        .pop_i      (w_wr_hs),
        .head_dat_o (w_head),
        .count_o    (w_fifo_count),
        .empty_o    (w_fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_rd_issued <= '0;
            r_wr_issued <= '0;
            r_rd_out    <= '0;
            r_cm_out    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_out <= r_rd_out + CW'(w_rd_hs) - CW'(w_push);
            r_cm_out <= w_cm_out_nxt;
            if (w_rd_hs) r_rd_issued <= r_rd_issued + LEN_WIDTH'(1);
            if (w_wr_hs) r_wr_issued <= r_wr_issued + LEN_WIDTH'(1);
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // The cycle carrying done_o still counts as the tail of DONE, so start is held off there too.
                    if (start_i && !r_done) begin
                        r_src       <= src_addr_i & ~ADDR_WIDTH'(3);
                        r_dst       <= dst_addr_i & ~ADDR_WIDTH'(3);
                        r_len       <= len_i;
                        r_rd_issued <= '0;
                        r_wr_issued <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= (len_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_wr_issued == r_len) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_cm_out_nxt == '0) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign mem_req_o  = w_mem_req;
    assign mem_addr_o = r_src + ADDR_WIDTH'({r_rd_issued, 2'b00});
    assign cm_req_o   = w_cm_req;
    assign cm_we_o    = w_cm_req;
    assign cm_be_o    = 4'hF;
    assign cm_add_o   = r_dst + ADDR_WIDTH'({r_wr_issued, 2'b00});
    assign cm_wdata_o = w_cm_req ? w_head : '0;
endmodule

// File: tb/tb_cgra_cmem_loader.sv
// Bench for cgra_cmem_loader: memory and context-memory responders plus a scoreboard of expected cm writes.
module tb_cgra_cmem_loader;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [11:0] len_i;
    logic        busy_o, done_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_rdata_i;
    logic        cm_req_o, cm_we_o, cm_gnt_i, cm_rvalid_i;
    logic [31:0] cm_add_o, cm_wdata_o;
    logic [3:0]  cm_be_o;

    cgra_cmem_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .cm_req_o(cm_req_o), .cm_add_o(cm_add_o), .cm_we_o(cm_we_o), .cm_be_o(cm_be_o),
        .cm_wdata_o(cm_wdata_o), .cm_gnt_i(cm_gnt_i), .cm_rvalid_i(cm_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] addr; int due; } rd_t;

    wr_t sb_q[$];
    rd_t mrsp_q[$];
    int  crsp_q[$];
    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0, mem_lat = 1, cm_lat = 1, cm_duty = 100;
    bit  hold_gnt = 0;
    int  b_fifo = 0, b_out = 0, done_cnt = 0, req_cnt = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Responders: drive grants and responses just after each rising edge.
    initial begin
        rd_t r;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; cm_gnt_i = 0; cm_rvalid_i = 0;
        forever begin
            @(posedge clk_i); #1;
            cyc++;
            mem_gnt_i = !hold_gnt;
            cm_gnt_i  = ($urandom_range(0, 99) < cm_duty);
            mem_rvalid_i = 0; mem_rdata_i = 0;
            if (mrsp_q.size() > 0 && mrsp_q[0].due <= cyc) begin
                r = mrsp_q.pop_front();
                mem_rvalid_i = 1; mem_rdata_i = data_of(r.addr);
            end
            cm_rvalid_i = 0;
            if (crsp_q.size() > 0 && crsp_q[0] <= cyc) begin
                void'(crsp_q.pop_front());
                cm_rvalid_i = 1;
            end
        end
    end

    // Monitor: sample on the falling edge, check writes, credit limit and drain, and track occupancy.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                b_fifo = 0; b_out = 0;
            end else begin
                if (mem_req_o || cm_req_o) req_cnt++;
                if (b_fifo + b_out >= 4) chk("credit_limit_mem_req", mem_req_o, 0);
                if (cm_req_o && cm_gnt_i) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL cm_write_unexpected: got write to %h, required none", cm_add_o);
                    end else begin
                        e = sb_q.pop_front();
                        chk("cm_addr", cm_add_o, e.addr);
                        chk("cm_wdata", cm_wdata_o, e.data);
                        chk("cm_we_be", {cm_we_o, cm_be_o}, 5'h1F);
                    end
                    crsp_q.push_back(cyc + cm_lat);
                end
                if (mem_req_o && mem_gnt_i) mrsp_q.push_back('{addr: mem_addr_o, due: cyc + mem_lat});
                if (done_o) begin
                    done_cnt++;
                    chk("drain_before_done", crsp_q.size(), 0);
                end
                if (mem_req_o && mem_gnt_i) b_out++;
                if (mem_rvalid_i && b_out > 0) begin b_out--; b_fifo++; end
                if (cm_req_o && cm_gnt_i) b_fifo--;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] s, d;
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        for (int i = 0; i < len; i++)
            sb_q.push_back('{addr: d + 32'(4 * i), data: data_of(s + 32'(4 * i))});
        @(posedge clk_i); #1;
        src_addr_i = src; dst_addr_i = dst; len_i = 12'(len); start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0; src_addr_i = 32'hBAD0_0000; dst_addr_i = 32'hBAD0_0000; len_i = 12'd7;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin @(posedge clk_i); t++; end
        if (done_cnt == d0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no done_o after %0d cycles, required one", tag, t);
        end
        repeat (4) @(posedge clk_i); #1;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_busy_low"}, busy_o, 0);
        chk({tag, "_words_left"}, sb_q.size(), 0);
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst, input int len);
        int d0;
        d0 = done_cnt;
        start_xfer(src, dst, len);
        wait_done(tag, d0);
    endtask

    initial begin
        int d0, rc, t;
        rst_ni = 0; start_i = 0; src_addr_i = 0; dst_addr_i = 0; len_i = 0;
        @(negedge clk_i);
        chk("rst_ctrl", {busy_o, done_o, mem_req_o, cm_req_o, cm_we_o}, 0);
        chk("rst_addr", {mem_addr_o, cm_add_o}, 0);
        chk("rst_wdata_be", {cm_wdata_o, cm_be_o}, 36'hF);
        repeat (2) @(posedge clk_i); #1 rst_ni = 1;

        run_xfer("basic", 32'h0000_1000, 32'h0000_0000, 8);

        // Zero length: done_o exactly two cycles after the start cycle, no bus traffic.
        rc = req_cnt; d0 = done_cnt;
        @(posedge clk_i); #1;
        len_i = 0; src_addr_i = 32'h100; dst_addr_i = 32'h200; start_i = 1;
        @(negedge clk_i); chk("zero_done_c0", done_o, 0);
        @(posedge clk_i); #1 start_i = 0;
        @(negedge clk_i); chk("zero_c1", {busy_o, done_o}, 2'b10);
        @(negedge clk_i); chk("zero_c2", {busy_o, done_o}, 2'b01);
        @(negedge clk_i); chk("zero_c3", done_o, 0);
        chk("zero_no_req", req_cnt - rc, 0);
        chk("zero_done_once", done_cnt - d0, 1);

        mem_lat = 3; cm_duty = 30;
        run_xfer("backpressure", 32'h0000_4000, 32'h0000_0100, 20);
        mem_lat = 1; cm_duty = 100;

        // Read stall: request and address must hold while the grant is withheld.
        @(negedge clk_i); hold_gnt = 1;
        d0 = done_cnt;
        start_xfer(32'h0000_3000, 32'h0000_0300, 3);
        t = 0;
        while (!mem_req_o && t < 20) begin @(negedge clk_i); t++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_req", mem_req_o, 1);
            chk("stall_addr", mem_addr_o, 32'h0000_3000);
        end
        hold_gnt = 0;
        wait_done("stall", d0);

        cm_lat = 4;
        run_xfer("drain", 32'h0000_6000, 32'h0000_0600, 5);
        cm_lat = 1;

        run_xfer("wrap", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 3);

        // Start pulsed mid-transfer must be ignored.
        d0 = done_cnt;
        start_xfer(32'h0000_7000, 32'h0000_0700, 10);
        repeat (3) @(posedge clk_i); #1;
        src_addr_i = 32'h9000; dst_addr_i = 32'h800; len_i = 12'd3; start_i = 1;
        @(posedge clk_i); #1 start_i = 0;
        wait_done("restart_ignored", d0);

        // Reset mid-RUN aborts immediately; stale responses after release are ignored.
        mem_lat = 3; cm_duty = 30;
        start_xfer(32'h0000_5000, 32'h0000_0500, 20);
        repeat (12) @(posedge clk_i); #1;
        rst_ni = 0;
        sb_q.delete();
        @(negedge clk_i);
        chk("midrst_ctrl", {busy_o, done_o, mem_req_o, cm_req_o, cm_we_o}, 0);
        chk("midrst_addr", {mem_addr_o, cm_add_o}, 0);
        chk("midrst_wdata_be", {cm_wdata_o, cm_be_o}, 36'hF);
        repeat (2) @(posedge clk_i); #1 rst_ni = 1;
        repeat (12) @(posedge clk_i);
        mem_lat = 1; cm_duty = 100;
        run_xfer("after_reset", 32'h0000_2000, 32'h0000_0040, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
